// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one I2C master engine between NUM_REQ clients,
// granting only after the bus has been idle for BUF_CYCLES clocks (tBUF).
module i2c_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int BUF_CYCLES = 64,
    parameter int BUF_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               bby,
    input  logic               al,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] lost,
    output logic               bus_free,
    output logic [1:0]         o_dbg_state
);

    // Handshake: a client holds req high for its whole transaction; gnt is the
    // registered answer and drops one clock after req falls.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [BUF_W-1:0]   LP_BUF  = BUF_W'(BUF_CYCLES);
    localparam logic [NUM_REQ-1:0] LP_ONE  = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   LP_LAST = IDX_W'(NUM_REQ - 1);

    state_t               r_state;
    logic [BUF_W-1:0]     r_cnt;
    logic                 r_bus_free;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_gnt_vld;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [NUM_REQ-1:0]   r_lost;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [NUM_REQ-1:0]   w_lost_nxt;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_win_lo;
    logic [IDX_W-1:0]     w_win_hi;
    logic                 w_hi_ok;

    // Bus-free counter: any busy clock restarts the tBUF measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bus_free <= 1'b0;
        end else begin
            r_bus_free <= (r_cnt == LP_BUF);
            if (bby) begin
                r_cnt <= '0;
            end else if (r_cnt != LP_BUF) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Winner is the first requester above last, else the lowest requester,
    // which is a search from last+1 wrapping modulo NUM_REQ.
    always_comb begin
        w_win_lo = '0;
        w_win_hi = '0;
        w_hi_ok  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_lo = IDX_W'(i);
                if (i > int'(r_last)) begin
                    w_win_hi = IDX_W'(i);
                    w_hi_ok  = 1'b1;
                end
            end
        end
        w_win = w_hi_ok ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_last_nxt  = r_last;
        w_lost_nxt  = '0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (r_bus_free && (req != '0)) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = LP_ONE << w_win;
                    w_idx_nxt   = w_win;
                    w_last_nxt  = w_win;
                end
            end
            ST_GRANT: begin
                if (al) begin
                    w_lost_nxt[r_gnt_idx] = 1'b1;
                end
                if (!req[r_gnt_idx]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = bby ? ST_DRAIN : ST_GAP;
                end
            end
            ST_DRAIN: begin
                w_gnt_nxt = '0;
                if (!bby) begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_idx <= '0;
            r_last    <= LP_LAST;
            r_lost    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_vld <= |w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_last    <= w_last_nxt;
            r_lost    <= w_lost_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_vld     = r_gnt_vld;
    assign gnt_idx     = r_gnt_idx;
    assign lost        = r_lost;
    assign bus_free    = r_bus_free;
    assign o_dbg_state = r_state;

endmodule
